// File: rtl/piso_shifter.sv
// -----------------------------------------------------------------------------
// piso_shifter
//  Parametrised parallel-in/serial-out shifter. Accepts a WIDTH-bit word through
//  a valid/ready handshake and emits it one bit per shift_en strobe, MSB- or
//  LSB-first, with busy/done status.
//
//  Parameters
//   WIDTH       data word width in bits (>= 2)
//   MSB_FIRST   1: din[WIDTH-1] leaves first; 0: din[0] leaves first
//   IDLE_LEVEL  level driven on sout while no word is in flight
//
//  Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   load_valid  source presents a word on din
//   load_ready  shifter can accept a word (IDLE only, low while reset asserted)
//   din         parallel data word, sampled only at the accept edge
//   shift_en    bit-rate strobe; advances one bit per clock when high in SHIFT
//   sout        serial data out (registered)
//   sout_valid  high while sout carries a data or parity bit
//   busy        high in SHIFT state
//   done        one-cycle pulse after the last bit is consumed
//
//  Build option
//   PISO_PARITY_EN  when defined, an even-parity bit of the captured word is sent
//                   after the last data bit and the frame becomes WIDTH+1 bits.
// -----------------------------------------------------------------------------
module piso_shifter #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [NBITS-1:0] shreg_r, shreg_s;
    logic [NBITS-1:0] frame_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             sout_r, sout_s;
    logic             sout_valid_r, sout_valid_s;
    logic             done_r, done_s;

`ifdef PISO_PARITY_EN
    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Build the frame so that the output end always holds the next bit to send;
    // the parity bit, when present, sits at the far end and leaves last.
    function automatic logic [NBITS-1:0] load_frame(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
        if (MSB_FIRST != 0) begin
            return {d, even_parity(d)};
        end else begin
            return {even_parity(d), d};
        end
`else
        return d;
`endif
    endfunction

    function automatic logic out_bit(input logic [NBITS-1:0] s);
        if (MSB_FIRST != 0) begin
            return s[NBITS-1];
        end else begin
            return s[0];
        end
    endfunction

    // Move the frame one place toward the output end, zero fill behind it.
    function automatic logic [NBITS-1:0] shift_word(input logic [NBITS-1:0] s);
        if (MSB_FIRST != 0) begin
            return {s[NBITS-2:0], 1'b0};
        end else begin
            return {1'b0, s[NBITS-1:1]};
        end
    endfunction

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            cnt_r        <= '0;
            sout_r       <= IDLE_LEVEL;
            sout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            cnt_r        <= cnt_s;
            sout_r       <= sout_s;
            sout_valid_r <= sout_valid_s;
            done_r       <= done_s;
        end
    end

    // Next-state and next-output logic; sout is computed one clock ahead so the
    // registered output shows the first bit the cycle after capture.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        cnt_s        = cnt_r;
        sout_s       = sout_r;
        sout_valid_s = sout_valid_r;
        done_s       = 1'b0;
        frame_s      = load_frame(din);
        case (state_r)
            IDLE: begin
                if (load_valid) begin
                    state_s      = SHIFT;
                    shreg_s      = frame_s;
                    cnt_s        = '0;
                    sout_s       = out_bit(frame_s);
                    sout_valid_s = 1'b1;
                end else begin
                    state_s      = IDLE;
                    sout_s       = IDLE_LEVEL;
                    sout_valid_s = 1'b0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_r == CW'(NBITS - 1)) begin
                        state_s      = IDLE;
                        cnt_s        = '0;
                        done_s       = 1'b1;
                        sout_s       = IDLE_LEVEL;
                        sout_valid_s = 1'b0;
                    end else begin
                        shreg_s      = shift_word(shreg_r);
                        cnt_s        = cnt_r + CW'(1);
                        sout_s       = out_bit(shift_word(shreg_r));
                        sout_valid_s = 1'b1;
                    end
                end else begin
                    sout_valid_s = 1'b1;
                end
            end
            default: begin
                state_s      = IDLE;
                cnt_s        = '0;
                sout_s       = IDLE_LEVEL;
                sout_valid_s = 1'b0;
            end
        endcase
    end

    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign done       = done_r;
    assign busy       = (state_r == SHIFT);
    // Held low while reset is asserted so the source sees ready only after release.
    assign load_ready = (state_r == IDLE) && !reset;

endmodule

// File: tb/tb_piso_shifter.sv
// -----------------------------------------------------------------------------
// tb_piso_shifter
//  Drives an MSB-first and an LSB-first piso_shifter (WIDTH=8) with the same
//  stimulus and compares every output each cycle against a queue-based model:
//  an accepted word becomes a queue of bits in send order, each shift_en in a
//  frame pops one bit, and the frame ends when the queue empties.
//  Define PISO_PARITY_EN for both bench and RTL to exercise the parity frame.
// -----------------------------------------------------------------------------
module tb_piso_shifter;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         shift_en = 1'b0;

    logic load_ready_m, sout_m, sout_valid_m, busy_m, done_m;
    logic load_ready_l, sout_l, sout_valid_l, busy_l, done_l;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit in_frame = 1'b0;
    bit exp_done = 1'b0;
    bit qm[$];
    bit ql[$];

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(IDLE)) dut_m (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_m),
        .din(din), .shift_en(shift_en), .sout(sout_m), .sout_valid(sout_valid_m),
        .busy(busy_m), .done(done_m)
    );

    piso_shifter #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(IDLE)) dut_l (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_l),
        .din(din), .shift_en(shift_en), .sout(sout_l), .sout_valid(sout_valid_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        exp_done = 1'b0;
        qm.delete();
        ql.delete();
    endtask

    // Advance the model across one active edge given the inputs seen at that edge.
    task automatic model_edge(input logic lv, input logic [W-1:0] d, input logic se);
        exp_done = 1'b0;
        if (!in_frame) begin
            if (lv) begin
                qm.delete();
                ql.delete();
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                end
`ifdef PISO_PARITY_EN
                qm.push_back(^d);
                ql.push_back(^d);
`endif
                in_frame = 1'b1;
            end
        end else if (se) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            if (qm.size() == 0) begin
                in_frame = 1'b0;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        logic em, el;
        em = in_frame ? qm[0] : IDLE;
        el = in_frame ? ql[0] : IDLE;
        check_val({ctx, ".sout_msb"},  sout_m, em);
        check_val({ctx, ".sout_lsb"},  sout_l, el);
        check_val({ctx, ".sout_valid"}, {sout_valid_l, sout_valid_m}, {in_frame, in_frame});
        check_val({ctx, ".busy"},      {busy_l, busy_m}, {in_frame, in_frame});
        check_val({ctx, ".done"},      {done_l, done_m}, {exp_done, exp_done});
        check_val({ctx, ".load_ready"}, {load_ready_l, load_ready_m}, {!in_frame, !in_frame});
    endtask

    // One clock: apply inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input string ctx, input logic lv, input logic [W-1:0] d, input logic se);
        load_valid = lv;
        din        = d;
        shift_en   = se;
        @(posedge clk);
        model_edge(lv, d, se);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        // Power-on reset, released away from a clock edge.
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("por");
        step("idle", 1'b0, 8'h00, 1'b1);

        // 0xA5 with shift_en held high: one bit per clock.
        step("a5_load", 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < W + 2; i++) step("a5_shift", 1'b0, W'($urandom), 1'b1);

        // 0x81 with shift_en every third clock: each bit held three clocks.
        step("x81_load", 1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 3 * (W + 1) + 3; i++) step("x81_shift", 1'b0, W'($urandom), (i % 3) == 2);

        // 0xFF offered while 0x00 shifts: ignored, then accepted in the done cycle.
        step("b2b_load", 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < W + 1; i++) step("b2b_hold", 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < W + 2; i++) step("b2b_next", 1'b0, 8'h00, 1'b1);

        // 0x07 exercises the parity bit when enabled.
        step("x07_load", 1'b1, 8'h07, 1'b1);
        for (int i = 0; i < W + 2; i++) step("x07_shift", 1'b0, W'($urandom), 1'b1);

        // Reset asserted mid-frame, between clock edges.
        step("rst_load", 1'b1, 8'hC3, 1'b1);
        step("rst_shift", 1'b0, 8'h00, 1'b1);
        step("rst_shift", 1'b0, 8'h00, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check_val("rst_mid.sout", {sout_l, sout_m}, {IDLE, IDLE});
        check_val("rst_mid.busy", {busy_l, busy_m}, 2'b00);
        check_val("rst_mid.done", {done_l, done_m}, 2'b00);
        check_val("rst_mid.sout_valid", {sout_valid_l, sout_valid_m}, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        compare_all("rst_release");
        step("rst_after", 1'b0, 8'h00, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 3) == 0), W'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
